instr_issue_seq: RTL



---
 rtl/instr_issue_pkg.sv | 6 +
 rtl/issue_prog_ram.sv | 17 +
 rtl/instr_issue_seq.sv | 97 +++++++++
 3 files changed

// File: rtl/instr_issue_pkg.sv
// instr_issue_pkg: shared types and constants for the instruction issue sequencer
package instr_issue_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
endpackage

// File: rtl/issue_prog_ram.sv
// issue_prog_ram: DEPTH x 32 program store, synchronous write, combinational read
module issue_prog_ram import instr_issue_pkg::*; #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WORD_W-1:0] o_rdata
);
  logic [WORD_W-1:0] r_mem [DEPTH];
  always_ff @(posedge i_clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/instr_issue_seq.sv
// instr_issue_seq: walks a loaded program store and issues words to the CPU GAP cycles apart
// Optional NOP_SKIP_EN: zero words are skipped in ISSUE at one cycle each instead of being issued.
module instr_issue_seq import instr_issue_pkg::*; #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int GAP    = 6
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [WORD_W-1:0] load_data,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              start,
  input  logic              stall,
  output logic [WORD_W-1:0] instrWord,
  output logic              newInstr,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [7:0] CNT_INIT = 8'(GAP-2);
  state_t r_state, w_state;
  logic [ADDR_W:0] r_len, w_len, w_start_len;
  logic [ADDR_W-1:0] r_pc, w_pc;
  logic [7:0] r_cnt, w_cnt;
  logic [WORD_W-1:0] r_word, w_word, w_rd;
  logic r_new, w_new, w_busy, w_last;
  issue_prog_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .i_clk  (Clk),
    .i_we   (load_en && !w_busy),
    .i_waddr(load_addr),
    .i_wdata(load_data),
    .i_raddr(r_pc),
    .o_rdata(w_rd)
  );
  assign w_busy = r_state == ISSUE || r_state == WAIT;
  assign w_last = {1'b0, r_pc} == r_len - (ADDR_W+1)'(1);
  assign w_start_len = prog_len > DEPTH_L ? DEPTH_L : prog_len;
  always_comb begin
    w_state = r_state;
    w_len = r_len;
    w_pc = r_pc;
    w_cnt = r_cnt;
    w_word = r_word;
    w_new = 1'b0;
    case (r_state)
      IDLE, DONE: if (start) begin
        w_len = w_start_len;
        w_pc = '0;
        w_state = w_start_len == '0 ? DONE : ISSUE;
      end
      ISSUE:
`ifdef NOP_SKIP_EN
        if (w_rd == NOP_WORD) begin
          w_state = w_last ? DONE : ISSUE;
          w_pc = w_last ? r_pc : r_pc + ADDR_W'(1);
        end else
`endif
        begin
          w_word = w_rd;
          w_new = 1'b1;
          w_cnt = CNT_INIT;
          w_state = WAIT;
        end
      WAIT: if (!stall) begin
        if (r_cnt == 8'd0) begin
          w_state = w_last ? DONE : ISSUE;
          w_pc = w_last ? r_pc : r_pc + ADDR_W'(1);
        end else w_cnt = r_cnt - 8'd1;
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge Clk)
    if (Reset) begin
      r_state <= IDLE;
      r_len <= '0;
      r_pc <= '0;
      r_cnt <= '0;
      r_word <= '0;
      r_new <= 1'b0;
    end else begin
      r_state <= w_state;
      r_len <= w_len;
      r_pc <= w_pc;
      r_cnt <= w_cnt;
      r_word <= w_word;
      r_new <= w_new;
    end
  assign instrWord = r_word;
  assign newInstr = r_new;
  assign pc = r_pc;
  assign busy = w_busy;
  assign done = r_state == DONE;
endmodule
